// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO, with sticky
// overrun and framing-error flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rxd,
  input  logic                     rd,
  input  logic                     clr_err,
  output logic [7:0]               rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     frame_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic          rxd_meta, rxd_sync, rxd_prev;
  logic [2:0]    primed;
  logic          fall;
  logic [15:0]   timer;
  logic          tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          push, frame_set;

  // primed holds off edge detection until rxd_prev carries a real line
  // sample, so a line already low at reset release is not taken as a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
      primed   <= '0;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
      primed   <= {primed[1:0], 1'b1};
    end
  end

  assign fall = primed[2] & rxd_prev & ~rxd_sync;
  assign tick = (timer == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (tick) state_nxt = rxd_sync ? IDLE : DATA;
      DATA:  if (tick && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    frame_set = 1'b0;
    if (state == STOP && tick) begin
      push      = rxd_sync;
      frame_set = ~rxd_sync;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE:  timer <= HALF_LAST;
        START: begin
          timer   <= tick ? BIT_LAST : timer - 16'd1;
          bit_idx <= '0;
        end
        DATA: begin
          timer <= tick ? BIT_LAST : timer - 16'd1;
          if (tick) begin
            bit_idx <= bit_idx + 3'd1;
            shift   <= {rxd_sync, shift[7:1]};
          end
        end
        default: timer <= timer - 16'd1;
      endcase
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, do_pop, do_push, drop;

  assign valid   = (count != '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = rd & valid;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rdata   = valid ? mem[rptr] : 8'h00;

  // NOTE: storage is not reset; rdata is masked by valid, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      // A set event in the same cycle as clr_err wins.
      if (drop)         overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Parameters
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per bit (115200 baud at 100 MHz); legal range 4..65535.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving receive FIFO entries; it SHALL be a power of two, 2..64.

Interface
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rxd  input  1  asynchronous serial line, idle high; 8 data bits, no parity, 1 stop bit, LSB first.
REQ-006 rd  input  1  pop strobe; CPU read of the data register.
REQ-007 clr_err  input  1  clears sticky error flags.
REQ-008 rdata  output  8  FIFO head byte; 0 when empty.
REQ-009 valid  output  1  FIFO non-empty.
REQ-010 count  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-011 overrun  output  1  sticky; a byte was dropped on full FIFO.
REQ-012 frame_err  output  1  sticky; stop bit sampled low.

Function
REQ-013 rxd SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-014 The receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE->START SHALL occur only on a synchronized high-to-low transition; a line held low SHALL NOT retrigger.
REQ-016 START SHALL wait CLKS_PER_BIT/2 cycles (integer division), then sample: low->DATA, high->IDLE (glitch rejected, nothing pushed, no flag).
REQ-017 DATA SHALL sample every CLKS_PER_BIT cycles, shifting 8 bits LSB first, then go to STOP.
REQ-018 STOP SHALL sample once after CLKS_PER_BIT cycles: high->push byte; low->discard byte and set frame_err; either way->IDLE.
REQ-019 A pushed byte SHALL appear in rdata with valid=1 and count incremented on the cycle after the stop-bit sample.
REQ-020 rdata SHALL be first-word-fall-through: the head is shown combinationally from FIFO storage, with no read latency.
REQ-021 rd with valid=1 SHALL pop one entry at the clock edge; rd with valid=0 SHALL be ignored, with no underflow and count unchanged.
REQ-022 A push on a full FIFO without a same-cycle pop SHALL drop the new byte, leave contents unchanged and set overrun.
REQ-023 A simultaneous push and pop SHALL both succeed: count unchanged, no overrun, even when full.
REQ-024 A simultaneous push and pop on an empty FIFO SHALL ignore the pop and accept the push (count=1).
REQ-025 Read and write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 clr_err SHALL clear overrun and frame_err next cycle; a same-cycle set event SHALL win (flag stays 1).

Reset
REQ-027 reset low SHALL immediately force FSM=IDLE, FIFO pointers=0, count=0, valid=0, rdata=0, overrun=0, frame_err=0, synchronizer flops=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame; the partial byte SHALL never be pushed.
REQ-029 After reset release, a frame already in progress SHALL be received only from its next falling edge.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-030 Send 0xA5 -> valid=1, rdata=0xA5, count=1, both flags 0; pulse rd -> valid=0, rdata=0.
REQ-031 Send 0x01,0x02,0x03,0x04,0x05 with no reads -> count=4, overrun=1; pops return 01,02,03,04; pulse clr_err -> overrun=0.
REQ-032 Send 0x3C with stop bit forced low -> count=0, frame_err=1; next good byte 0x7E -> rdata=0x7E.
REQ-033 A 1-cycle low pulse on rxd -> FSM returns to IDLE, count=0, no flags set.
REQ-034 FIFO full (4 entries); assert rd on the same cycle as the 5th byte's push -> count=4, overrun=0, order preserved.
REQ-035 Assert reset during DATA of 0x55, release, then send 0x99 -> only 0x99 is received, count=1.
